// File: rtl/gcd_lcm.sv
// LCM post-processor for the GCD response stream: pairs operands with g, then lcm = (a / g) * b.
// Optional GCD_LCM_FASTPATH_EN shortens latency for g==1 and g==a; results are identical.
module gcd_lcm #(
  parameter int unsigned XLEN = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*XLEN-1:0]   op_msg,
  input  logic                op_val,
  output logic                op_rdy,
  input  logic [XLEN-1:0]     gcd_msg,
  input  logic                gcd_val,
  output logic                gcd_rdy,
  output logic [2*XLEN-1:0]   resp_msg,
  output logic                resp_val,
  input  logic                resp_rdy
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_G,
    DIV,
    MUL,
    DONE
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_a;        // dividend, then quotient, then multiplier
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_g;
  logic [XLEN-1:0]   r_rem;
  logic [PW-1:0]     r_mcand;
  logic [PW-1:0]     r_p;
  logic [CW-1:0]     r_cnt;
  logic              r_op_rdy;
  logic              r_gcd_rdy;
  logic              r_resp_val;
  logic [PW-1:0]     r_resp_msg;

  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic              w_last;
  logic [PW-1:0]     w_p_add;
  logic              w_zero;

  // Restoring-division step: shift next dividend bit into the partial remainder.
  assign w_rem_sh  = {r_rem, r_a[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_g});
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_g;
  assign w_last    = (r_cnt == CW'(XLEN - 1));
  assign w_p_add   = r_p + (r_a[0] ? r_mcand : '0);
  assign w_zero    = (r_a == '0) || (r_b == '0) || (gcd_msg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_g        <= '0;
      r_rem      <= '0;
      r_mcand    <= '0;
      r_p        <= '0;
      r_cnt      <= '0;
      r_op_rdy   <= 1'b1;
      r_gcd_rdy  <= 1'b0;
      r_resp_val <= 1'b0;
      r_resp_msg <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (op_val && r_op_rdy) begin
            r_a       <= op_msg[PW-1:XLEN];
            r_b       <= op_msg[XLEN-1:0];
            r_mcand   <= PW'(op_msg[XLEN-1:0]);
            r_p       <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_op_rdy  <= 1'b0;
            r_gcd_rdy <= 1'b1;
            r_state   <= WAIT_G;
          end
        end

        WAIT_G: begin
          if (gcd_val && r_gcd_rdy) begin
            r_g       <= gcd_msg;
            r_gcd_rdy <= 1'b0;
            if (w_zero) begin
              r_resp_msg <= '0;
              r_resp_val <= 1'b1;
              r_state    <= DONE;
`ifdef GCD_LCM_FASTPATH_EN
            end else if (gcd_msg == r_a) begin
              r_resp_msg <= PW'(r_b);
              r_resp_val <= 1'b1;
              r_state    <= DONE;
            end else if (gcd_msg == XLEN'(1)) begin
              r_state <= MUL;
`endif
            end else begin
              r_state <= DIV;
            end
          end
        end

        DIV: begin
          r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
          r_a   <= {r_a[XLEN-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= MUL;
          end
        end

        MUL: begin
          r_p     <= w_p_add;
          r_mcand <= r_mcand << 1;
          r_a     <= r_a >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt      <= '0;
            r_resp_msg <= w_p_add;
            r_resp_val <= 1'b1;
            r_state    <= DONE;
          end
        end

        DONE: begin
          if (resp_rdy) begin
            r_resp_val <= 1'b0;
            r_op_rdy   <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_op_rdy   <= 1'b1;
          r_gcd_rdy  <= 1'b0;
          r_resp_val <= 1'b0;
        end
      endcase
    end
  end

  assign op_rdy   = r_op_rdy;
  assign gcd_rdy  = r_gcd_rdy;
  assign resp_val = r_resp_val;
  assign resp_msg = r_resp_msg;

endmodule

// File: tb/tb_gcd_lcm.sv
// Directed-vector bench for gcd_lcm: results, latency, pairing, backpressure and mid-run reset.
module tb_gcd_lcm;

  localparam int unsigned XLEN = 16;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int L_FULL = 33;
  localparam int L_ZERO = 1;
`ifdef GCD_LCM_FASTPATH_EN
  localparam int L_ONE = 17;
  localparam int L_EQ  = 1;
`else
  localparam int L_ONE = 33;
  localparam int L_EQ  = 33;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [PW-1:0]   op_msg;
  logic            op_val;
  logic            op_rdy;
  logic [XLEN-1:0] gcd_msg;
  logic            gcd_val;
  logic            gcd_rdy;
  logic [PW-1:0]   resp_msg;
  logic            resp_val;
  logic            resp_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  gcd_lcm #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_msg   (op_msg),
    .op_val   (op_val),
    .op_rdy   (op_rdy),
    .gcd_msg  (gcd_msg),
    .gcd_val  (gcd_val),
    .gcd_rdy  (gcd_rdy),
    .resp_msg (resp_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int n;
    n = 0;
    op_val = 1'b1;
    op_msg = {a, b};
    while (!op_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("op_rdy_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    op_val = 1'b0;
  endtask

  task automatic send_gcd(input logic [XLEN-1:0] g);
    int n;
    n = 0;
    gcd_val = 1'b1;
    gcd_msg = g;
    while (!gcd_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("gcd_rdy_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    gcd_val = 1'b0;
  endtask

  // Called #1 after the gcd transfer edge; latency counts that cycle as 1.
  task automatic wait_resp(input string tag, input logic [PW-1:0] exp,
                           input int exp_lat, input int hold);
    int lat;
    lat = 1;
    while (!resp_val && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_msg"}, 64'(resp_msg), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_msg"}, 64'(resp_msg), 64'(exp));
      check({tag, "_hold_val"}, 64'(resp_val), 64'd1);
      check({tag, "_hold_oprdy"}, 64'(op_rdy), 64'd0);
      check({tag, "_hold_gcdrdy"}, 64'(gcd_rdy), 64'd0);
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    check({tag, "_val_drop"}, 64'(resp_val), 64'd0);
    check({tag, "_op_rdy_back"}, 64'(op_rdy), 64'd1);
  endtask

  task automatic txn(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] g, input logic [PW-1:0] exp, input int exp_lat);
    send_op(a, b);
    send_gcd(g);
    wait_resp(tag, exp, exp_lat, 0);
  endtask

  initial begin
    int pulses;
    reset    = 1'b1;
    op_val   = 1'b0;
    op_msg   = '0;
    gcd_val  = 1'b0;
    gcd_msg  = '0;
    resp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_rdy", 64'(op_rdy), 64'd1);
    check("rst_gcd_rdy", 64'(gcd_rdy), 64'd0);
    check("rst_resp_val", 64'(resp_val), 64'd0);
    check("rst_resp_msg", 64'(resp_msg), 64'd0);
    reset = 1'b0;

    txn("t48_18", 16'd48, 16'd18, 16'd6, 32'd144, L_FULL);
    txn("t1701", 16'd1701, 16'd199, 16'd1, 32'd338499, L_ONE);
    txn("t22000", 16'd22000, 16'd19900, 16'd100, 32'd4378000, L_FULL);
    txn("t17", 16'd17, 16'd289, 16'd17, 32'd289, L_EQ);
    txn("tmax", 16'd65535, 16'd65534, 16'd1, 32'd4294770690, L_ONE);
    txn("tzero", 16'd0, 16'd5, 16'd5, 32'd0, L_ZERO);

    // gcd_val arriving with op_val in IDLE must be ignored
    op_val  = 1'b1;
    op_msg  = {16'd12, 16'd8};
    gcd_val = 1'b1;
    gcd_msg = 16'd7;
    #1;
    check("idle_gcd_rdy", 64'(gcd_rdy), 64'd0);
    check("idle_op_rdy", 64'(op_rdy), 64'd1);
    @(posedge clk); #1;
    op_val  = 1'b0;
    gcd_msg = 16'd4;
    check("waitg_gcd_rdy", 64'(gcd_rdy), 64'd1);
    check("waitg_op_rdy", 64'(op_rdy), 64'd0);
    check("waitg_resp_val", 64'(resp_val), 64'd0);
    @(posedge clk); #1;
    gcd_val = 1'b0;
    wait_resp("pair", 32'd24, L_FULL, 0);

    // Backpressure: hold resp_rdy low for 10 cycles in DONE
    resp_rdy = 1'b0;
    send_op(16'd48, 16'd18);
    send_gcd(16'd6);
    wait_resp("bp", 32'd144, L_FULL, 10);

    // Reset during MUL aborts without a response
    send_op(16'd48, 16'd18);
    send_gcd(16'd6);
    repeat (20) @(posedge clk);
    #1;
    check("mid_resp_val", 64'(resp_val), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst2_op_rdy", 64'(op_rdy), 64'd1);
    check("rst2_gcd_rdy", 64'(gcd_rdy), 64'd0);
    check("rst2_resp_val", 64'(resp_val), 64'd0);
    check("rst2_resp_msg", 64'(resp_msg), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_val) pulses++;
    end
    check("rst2_no_pulse", 64'(pulses), 64'd0);
    txn("after_rst", 16'd12, 16'd8, 16'd4, 32'd24, L_FULL);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gcd_lcm.md
Name: gcd_lcm

Overview:
- Downstream consumer of the GCD core's response stream. Pairs each GCD result with the operand pair that produced it, then computes LCM = (a / g) * b.
- Sequential datapath: restoring divider, then shift-add multiplier.
- Sits between the GCD core's resp port and the system result sink. Operands arrive through a separate operand-side handshake that the issuer drives alongside the GCD request.

Parameters:
XLEN, 16, operand and GCD width; LCM result is 2*XLEN bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op_msg  input  2*XLEN  operand pair {a[2*XLEN-1:XLEN], b[XLEN-1:0]}, same packing as the GCD req_msg
op_val  input  1  operand pair valid
op_rdy  output  1  block can accept an operand pair
gcd_msg  input  XLEN  GCD result g, connected to the GCD core's resp_msg
gcd_val  input  1  connected to the GCD core's resp_val
gcd_rdy  output  1  connected to the GCD core's resp_rdy
resp_msg  output  2*XLEN  LCM result
resp_val  output  1  LCM result valid
resp_rdy  input  1  downstream ready

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Transfer rule: a transfer occurs on a rising edge where val && rdy. rdy outputs are registered-state decodes only, with no combinational path from any val.
- FSM states: IDLE, WAIT_G, DIV, MUL, DONE.
- Reset values: state=IDLE, op_rdy=1, gcd_rdy=0, resp_val=0, resp_msg=0, all internal registers 0.
- IDLE: op_rdy=1. On op transfer, capture a and b, go to WAIT_G.
  - gcd_val in IDLE is ignored (gcd_rdy=0), including when it coincides with op_val; only the op transfer is taken.
- WAIT_G: gcd_rdy=1, op_rdy=0. On gcd transfer, capture g.
  - If a==0, b==0 or g==0: result=0, go to DONE.
  - Otherwise go to DIV.
- DIV: restoring division q = a / g, one quotient bit per cycle, MSB first, exactly XLEN cycles. Then go to MUL.
  - The remainder is computed internally and discarded.
- MUL: shift-add product p = q * b, one multiplier bit per cycle, exactly XLEN cycles, 2*XLEN-bit accumulator with no truncation. Then go to DONE with resp_msg=p.
- DONE: resp_val=1, resp_msg held stable until transfer. On resp transfer: resp_val=0, go to IDLE.
  - op_rdy=0 in DONE; no overlap with the next operand.
- Latency (without macro): gcd transfer at edge N; DIV occupies N+1..N+XLEN; MUL occupies N+XLEN+1..N+2*XLEN; resp_val=1 from the cycle after edge N+2*XLEN (33 cycles for XLEN=16).
  - Zero case: resp_val=1 in the cycle after edge N.
- Width: (a/g)*b < 2^(2*XLEN) for all inputs, so no overflow is possible.
- Ordering: strictly one transaction in flight; the op and gcd pairing is in order by construction.
- Reset mid-operation, in any state: abort, return to the reset values in the next cycle, discard the partial result, no resp_val pulse.
- resp_rdy held low: stay in DONE indefinitely; op_rdy and gcd_rdy stay 0, so backpressure propagates into the GCD core.

Optional Feature:
GCD_LCM_FASTPATH_EN
- Defined, g==1 (nonzero a, b): skip DIV, set q=a, enter MUL directly. resp_val=1 XLEN+1 cycles after the gcd transfer.
- Defined, g==a (nonzero a, b): skip DIV and MUL, result = b (zero-extended). resp_val=1 in the cycle after the gcd transfer.
- Defined: the zero case is unchanged.
- Not defined: every nonzero case takes the full 2*XLEN DIV+MUL latency.
- Results are bit-identical either way; only latency differs.

Test Plan:
- op=(48,18), g=6, resp_rdy=1 -> resp_msg=144, resp_val rises exactly 33 cycles after the gcd transfer (no macro).
- op=(1701,199), g=1 -> resp_msg=338499. Latency 33 cycles without the macro, 17 cycles with GCD_LCM_FASTPATH_EN.
- op=(22000,19900), g=100 -> 4378000. op=(17,289), g=17 -> 289; with the macro this result appears 1 cycle after the gcd transfer.
- op=(65535,65534), g=1 -> 4294770690 (no truncation). op=(0,5), g=5 -> 0 one cycle after the gcd transfer.
- Backpressure/pairing:
  - gcd_val asserted in IDLE together with op_val -> only op is accepted, gcd_rdy=0 that cycle.
  - resp_rdy=0 for 10 cycles in DONE -> resp_msg stable, op_rdy=0 and gcd_rdy=0 throughout.
- reset pulsed for 1 cycle during MUL of (48,18) -> next cycle IDLE with resp_val=0. A fresh op=(12,8), g=4 then yields 24.
